// File: rtl/udp_lb_pkg.sv
// udp_lb_pkg: shared types, widths and helpers for the UDP loopback buffer.
package udp_lb_pkg;

    localparam int LEN_W  = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2
    } rd_state_e;

    // Round a byte count up to whole 32-bit words. The sum is one bit wider
    // so that counts near 16'hFFFF do not wrap.
    function automatic logic [LEN_W-1:0] bytes2words(input logic [LEN_W-1:0] bytes);
        return LEN_W'(({1'b0, bytes} + (LEN_W+1)'(3)) >> 2);
    endfunction

endpackage

// File: rtl/udp_lb_sdp_ram.sv
// udp_lb_sdp_ram: simple dual-port RAM, one write port and one registered
// read port on the same clock. Read-during-write returns the old contents.
module udp_lb_sdp_ram #(
    parameter int DW = 32,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/udp_loopback_buf.sv
// udp_loopback_buf: store-and-forward packet buffer between UDP receive and
// transmit. Whole packets are committed (or dropped) at rec_pkt_done; each
// committed packet launches one transmit with its byte count.
// Optional build macro UDP_LB_STAT_EN adds saturating forward/drop counters.
module udp_loopback_buf
    import udp_lb_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int LQ_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_en,
    input  logic [DATA_W-1:0] rec_data,
    input  logic              rec_pkt_done,
    input  logic [LEN_W-1:0]  rec_byte_num,
    output logic              tx_start_en,
    output logic [LEN_W-1:0]  tx_byte_num,
    input  logic              tx_req,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done,
    output logic              drop_pulse
`ifdef UDP_LB_STAT_EN
    ,
    output logic [15:0]       pkt_fwd_cnt,
    output logic [15:0]       pkt_drop_cnt
`endif
);

    localparam int DEPTH    = 2**ADDR_W;
    localparam int LQ_DEPTH = 2**LQ_W;

    // One extra bit on every pointer makes occupancy subtraction wrap-safe.
    typedef logic [ADDR_W:0] ptr_t;

    ptr_t wr_ptr_q, wr_tmp_q, rd_ptr_q, free_ptr_q;
    logic ovf_q, drop_q, data_vld_q;
    logic [LQ_W-1:0] lq_wr_q, lq_rd_q;
    logic [LQ_W:0]   lq_cnt_q;
    logic            lq_stale_q;
    rd_state_e       state_q, state_d;
    logic [LEN_W-1:0] tx_len_q, rem_q;

    ptr_t used, wr_tmp_d, pkt_words;
    logic wr_full, wr_acc, ovf_d, lq_full, commit, drop_d, pop, rd_en;
    logic [LEN_W-1:0]  rec_words, lq_rdata;
    logic [DATA_W-1:0] ram_rdata;

    // Write acceptance and commit decision. Space is measured against the
    // start of the oldest unreleased packet, so nothing committed is reused
    // before its tx_done.
    always_comb begin
        used      = wr_tmp_q - free_ptr_q;
        wr_full   = (used == ptr_t'(DEPTH-1));
        wr_acc    = rec_en && !ovf_q && !wr_full;
        ovf_d     = ovf_q || (rec_en && wr_full);
        wr_tmp_d  = wr_tmp_q + ptr_t'(wr_acc);
        pkt_words = wr_tmp_d - wr_ptr_q;
        rec_words = bytes2words(rec_byte_num);
        lq_full   = (lq_cnt_q == (LQ_W+1)'(LQ_DEPTH));
        commit    = rec_pkt_done && !ovf_d && (rec_byte_num != '0) &&
                    (rec_words == LEN_W'(pkt_words)) && !lq_full;
        drop_d    = rec_pkt_done && !commit;
        pop       = tx_done && (state_q == START || state_q == SEND);
    end

    // Write pointers: speculative wr_tmp, committed wr_ptr, rollback on drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            wr_tmp_q <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= drop_d;
            if (rec_pkt_done) begin
                wr_tmp_q <= commit ? wr_tmp_d : wr_ptr_q;
                if (commit) wr_ptr_q <= wr_tmp_d;
                ovf_q <= 1'b0;
            end else begin
                wr_tmp_q <= wr_tmp_d;
                ovf_q    <= ovf_d;
            end
        end
    end

    // Length queue pointers. The stale flag covers the cycle after the head
    // slot changes, when the registered read port still shows old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lq_wr_q    <= '0;
            lq_rd_q    <= '0;
            lq_cnt_q   <= '0;
            lq_stale_q <= 1'b0;
        end else begin
            lq_wr_q    <= lq_wr_q + LQ_W'(commit);
            lq_rd_q    <= lq_rd_q + LQ_W'(pop);
            lq_stale_q <= pop || (commit && lq_wr_q == lq_rd_q);
            case ({commit, pop})
                2'b10:   lq_cnt_q <= lq_cnt_q + 1'b1;
                2'b01:   lq_cnt_q <= lq_cnt_q - 1'b1;
                default: lq_cnt_q <= lq_cnt_q;
            endcase
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Read FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (lq_cnt_q != '0 && !lq_stale_q) state_d = START;
            START:   state_d = tx_done ? IDLE : SEND;
            SEND:    if (tx_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        tx_start_en = (state_q == START);
        rd_en       = (state_q == SEND) && tx_req && (rem_q != '0);
    end

    // Read datapath: load head length, walk the packet, skip the unread
    // tail and release its space on tx_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_len_q   <= '0;
            rem_q      <= '0;
            rd_ptr_q   <= '0;
            free_ptr_q <= '0;
            data_vld_q <= 1'b0;
        end else begin
            data_vld_q <= rd_en;
            if (state_q == IDLE && state_d == START) begin
                tx_len_q <= lq_rdata;
                rem_q    <= bytes2words(lq_rdata);
            end else if (pop) begin
                rd_ptr_q   <= rd_ptr_q + ptr_t'(rem_q);
                free_ptr_q <= rd_ptr_q + ptr_t'(rem_q);
                rem_q      <= '0;
            end else if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rem_q    <= rem_q - 1'b1;
            end
        end
    end

    udp_lb_sdp_ram #(.DW(DATA_W), .AW(ADDR_W)) u_data_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_tmp_q[ADDR_W-1:0]),
        .wdata_i (rec_data),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    udp_lb_sdp_ram #(.DW(LEN_W), .AW(LQ_W)) u_len_ram (
        .clk     (clk),
        .we_i    (commit),
        .waddr_i (lq_wr_q),
        .wdata_i (rec_byte_num),
        .re_i    (1'b1),
        .raddr_i (lq_rd_q),
        .rdata_o (lq_rdata)
    );

    assign tx_byte_num = tx_len_q;
    assign tx_data     = data_vld_q ? ram_rdata : '0;
    assign drop_pulse  = drop_q;

`ifdef UDP_LB_STAT_EN
    logic [15:0] fwd_cnt_q, drop_cnt_q;

    // Saturating forwarded/dropped packet counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (pop && fwd_cnt_q != 16'hFFFF)     fwd_cnt_q  <= fwd_cnt_q + 16'd1;
            if (drop_d && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign pkt_fwd_cnt  = fwd_cnt_q;
    assign pkt_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_udp_loopback_buf.sv
// tb_udp_loopback_buf: directed bench with a queue-based packet model.
// Built with ADDR_W=4 (15 usable words) and LQ_W=3 (8 pending packets).
`timescale 1ns/1ps
module tb_udp_loopback_buf;

    localparam int ADDR_W   = 4;
    localparam int LQ_W     = 3;
    localparam int DEPTH    = 16;
    localparam int LQ_DEPTH = 8;

    logic        clk = 1'b0, rst = 1'b1;
    logic        rec_en = 1'b0, rec_pkt_done = 1'b0, tx_req = 1'b0, tx_done = 1'b0;
    logic [31:0] rec_data = '0;
    logic [15:0] rec_byte_num = '0;
    logic        tx_start_en, drop_pulse;
    logic [15:0] tx_byte_num;
    logic [31:0] tx_data;
`ifdef UDP_LB_STAT_EN
    logic [15:0] pkt_fwd_cnt, pkt_drop_cnt;
`endif

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    udp_loopback_buf #(.ADDR_W(ADDR_W), .LQ_W(LQ_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .rec_en       (rec_en),
        .rec_data     (rec_data),
        .rec_pkt_done (rec_pkt_done),
        .rec_byte_num (rec_byte_num),
        .tx_start_en  (tx_start_en),
        .tx_byte_num  (tx_byte_num),
        .tx_req       (tx_req),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
        .drop_pulse   (drop_pulse)
`ifdef UDP_LB_STAT_EN
        ,
        .pkt_fwd_cnt  (pkt_fwd_cnt),
        .pkt_drop_cnt (pkt_drop_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ---------------- packet-level model ----------------
    logic [31:0] cur_q[$];        // words of the packet being received
    bit          ovf_m;
    int          pend_len[$];     // committed, not yet released packets
    logic [31:0] pend_data[$];    // their words, oldest first
    bit          active;          // head packet is being transmitted
    int          idx, cur_len;
    bit          exp_drop, exp_chk;
    logic [31:0] exp_data;
    int          fwd_m, drop_m;
    int          starts_seen = 0, served = 0, drops_seen = 0;
    int          obs_len[$];
    logic [31:0] obs_data[$];

    function automatic int w(input int b);
        return (b + 3) / 4;
    endfunction

    // Apply this edge's inputs to the model.
    always @(posedge clk) begin
        exp_drop = 0; exp_chk = 0; exp_data = '0;
        if (rst) begin
            cur_q.delete(); pend_len.delete(); pend_data.delete();
            ovf_m = 0; active = 0; idx = 0; fwd_m = 0; drop_m = 0;
        end else begin
            if (active && tx_req) begin
                exp_chk = 1;
                if (idx < w(pend_len[0])) begin
                    exp_data = pend_data[idx];
                    idx++;
                end
            end
            if (rec_en) begin
                if (!ovf_m && pend_data.size() + cur_q.size() + 1 < DEPTH) cur_q.push_back(rec_data);
                else ovf_m = 1;
            end
            if (rec_pkt_done) begin
                if (!ovf_m && rec_byte_num != 0 && w(int'(rec_byte_num)) == cur_q.size() &&
                    pend_len.size() < LQ_DEPTH) begin
                    pend_len.push_back(int'(rec_byte_num));
                    foreach (cur_q[i]) pend_data.push_back(cur_q[i]);
                end else begin
                    exp_drop = 1;
                    drop_m++;
                end
                cur_q.delete();
                ovf_m = 0;
            end
            if (tx_done && active) begin
                repeat (w(pend_len[0])) void'(pend_data.pop_front());
                void'(pend_len.pop_front());
                active = 0;
                fwd_m++;
            end
        end
    end

    // Compare DUT outputs against the model every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("drop_pulse", 32'(drop_pulse), 32'(exp_drop));
            if (drop_pulse) drops_seen++;
            if (exp_chk) begin
                chk("tx_data", tx_data, exp_data);
                obs_data.push_back(tx_data);
            end
            if (tx_start_en) begin
                checks++;
                if (active || pend_len.size() == 0) begin
                    errors++;
                    $display("FAIL tx_start_unexpected actual=1 expected=0 (active=%0d pending=%0d)",
                             active, pend_len.size());
                end else begin
                    chk("tx_byte_num_at_start", 32'(tx_byte_num), 32'(pend_len[0]));
                    active = 1; idx = 0; cur_len = pend_len[0];
                    starts_seen++;
                    obs_len.push_back(int'(tx_byte_num));
                end
            end else if (active) begin
                chk("tx_byte_num_hold", 32'(tx_byte_num), 32'(cur_len));
            end
`ifdef UDP_LB_STAT_EN
            chk("pkt_fwd_cnt", 32'(pkt_fwd_cnt), 32'(fwd_m));
            chk("pkt_drop_cnt", 32'(pkt_drop_cnt), 32'(drop_m));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_pkt(input int nw, input int bn, input logic [31:0] base);
        for (int i = 0; i < nw; i++) begin
            rec_en = 1'b1; rec_data = base + 32'(i);
            rec_pkt_done = (i == nw - 1); rec_byte_num = 16'(bn);
            tick();
        end
        rec_en = 1'b0; rec_pkt_done = 1'b0;
        tick();
    endtask

    task automatic wait_start();
        int t = 0;
        while (starts_seen <= served && t < 100) begin tick(); t++; end
        checks++;
        if (starts_seen <= served) begin
            errors++;
            $display("FAIL tx_start_timeout actual=%0d expected=%0d", starts_seen, served + 1);
        end
        served++;
    endtask

    task automatic run(input int nreq);
        for (int i = 0; i < nreq; i++) begin tx_req = 1'b1; tick(); end
        tx_req = 1'b0; tx_done = 1'b1; tick();
        tx_done = 1'b0; tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_start_en", 32'(tx_start_en), 32'd0);
        chk("rst_tx_byte_num", 32'(tx_byte_num), 32'd0);
        chk("rst_tx_data", tx_data, 32'd0);
        chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        tick(); rst = 1'b0; tick();

        // 13 bytes in 4 words, one extra request returns zero.
        send_pkt(4, 13, 32'hA000_0000);
        wait_start(); run(5);
        chk("t1_len", 32'(obs_len[0]), 32'd13);
        chk("t1_w0", obs_data[0], 32'hA000_0000);
        chk("t1_w3", obs_data[3], 32'hA000_0003);
        chk("t1_extra", obs_data[4], 32'h0);

        // Length mismatch is dropped, next packet goes through.
        send_pkt(3, 8, 32'hB100_0000);
        repeat (6) tick();
        chk("t2_drops", 32'(drops_seen), 32'd1);
        chk("t2_no_start", 32'(starts_seen), 32'd1);
        send_pkt(2, 5, 32'hB200_0000);
        wait_start(); run(2);
        chk("t2_len", 32'(obs_len[$]), 32'd5);
        chk("t2_w1", obs_data[$], 32'hB200_0001);

        // Capacity: 20 and 16 words overflow, 15 fits.
        send_pkt(20, 80, 32'hC100_0000);
        send_pkt(16, 64, 32'hC200_0000);
        chk("t3_drops", 32'(drops_seen), 32'd3);
        send_pkt(15, 60, 32'hC300_0000);
        wait_start(); run(15);
        chk("t3_len", 32'(obs_len[$]), 32'd60);
        chk("t3_w14", obs_data[$], 32'hC300_000E);

        // Nine back-to-back single-word packets: queue holds eight.
        for (int i = 0; i < 9; i++) begin
            rec_en = 1'b1; rec_data = 32'hD000_0000 + 32'(i);
            rec_pkt_done = 1'b1; rec_byte_num = 16'd4;
            tick();
        end
        rec_en = 1'b0; rec_pkt_done = 1'b0; tick();
        chk("t4_drops", 32'(drops_seen), 32'd4);
        n0 = obs_data.size();
        for (int i = 0; i < 8; i++) begin wait_start(); run(1); end
        for (int i = 0; i < 8; i++) chk("t4_order", obs_data[n0 + i], 32'hD000_0000 + 32'(i));

        // Commit of B in the same cycle as tx_done of A.
        send_pkt(1, 4, 32'hE100_0000);
        wait_start();
        tx_req = 1'b1; tick();
        tx_req = 1'b0; rec_en = 1'b1; rec_data = 32'hE200_0000; tick();
        rec_data = 32'hE200_0001; rec_pkt_done = 1'b1; rec_byte_num = 16'd8; tx_done = 1'b1; tick();
        rec_en = 1'b0; rec_pkt_done = 1'b0; tx_done = 1'b0; tick();
        wait_start(); run(2);
        chk("t5_len", 32'(obs_len[$]), 32'd8);
        chk("t5_w0", obs_data[obs_data.size() - 2], 32'hE200_0000);
        chk("t5_w1", obs_data[$], 32'hE200_0001);

        // Reset in the middle of SEND.
        send_pkt(4, 16, 32'hF100_0000);
        wait_start();
        tx_req = 1'b1; tick(); tick();
        tx_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst2_tx_data", tx_data, 32'd0);
        chk("rst2_tx_byte_num", 32'(tx_byte_num), 32'd0);
        chk("rst2_tx_start_en", 32'(tx_start_en), 32'd0);
        tick(); rst = 1'b0;
        n0 = starts_seen;
        repeat (10) tick();
        chk("rst2_no_start", 32'(starts_seen), 32'(n0));
        send_pkt(2, 6, 32'hF200_0000);
        wait_start(); run(2);
        chk("t6_len", 32'(obs_len[$]), 32'd6);
        chk("t6_w1", obs_data[$], 32'hF200_0001);
`ifdef UDP_LB_STAT_EN
        @(negedge clk);
        chk("stat_fwd_lit", 32'(pkt_fwd_cnt), 32'd1);
        chk("stat_drop_lit", 32'(pkt_drop_cnt), 32'd0);
`endif
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
